// File: rtl/memaccess.sv
// rtl/memaccess.sv - memory-access pipeline stage: M register, SRAM load/store control, A (writeback) register
module memaccess (
    input  logic        clock,
    input  logic        reset,
    input  logic        regwrite_E,
    input  logic [4:0]  writeRegE,
    input  logic        memread_E,
    input  logic        memwrite_E,
    input  logic [1:0]  memsize_E,
    input  logic        memsigned_E,
    input  logic [31:0] aluout_E,
    input  logic [31:0] writedata_E,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        stall_M,
    output logic        addrerr_M,
    output logic        regwrite_A,
    output logic [4:0]  writeRegA,
    output logic [31:0] resultA
);

    typedef enum logic {
        IDLE     = 1'b0,
        LOADWAIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic        regwrite_M;
    logic [4:0]  writeRegM;
    logic        memread_M;
    logic        memwrite_M;
    logic [1:0]  memsize_M;
    logic        memsigned_M;
    logic [31:0] aluout_M;
    logic [31:0] writedata_M;

    logic        misaligned;
    logic        is_load;
    logic        is_store;
    logic [3:0]  store_wen;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    logic        a_load;
    logic        a_regwrite;
    logic [31:0] a_result;

    // M register: stalled loads keep their fields so LOADWAIT can still see them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regwrite_M  <= 1'b0;
            writeRegM   <= 5'd0;
            memread_M   <= 1'b0;
            memwrite_M  <= 1'b0;
            memsize_M   <= 2'b00;
            memsigned_M <= 1'b0;
            aluout_M    <= 32'd0;
            writedata_M <= 32'd0;
        end else if (!stall_M) begin
            regwrite_M  <= regwrite_E;
            writeRegM   <= writeRegE;
            memread_M   <= memread_E;
            memwrite_M  <= memwrite_E;
            memsize_M   <= memsize_E;
            memsigned_M <= memsigned_E;
            aluout_M    <= aluout_E;
            writedata_M <= writedata_E;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regwrite_A <= 1'b0;
            writeRegA  <= 5'd0;
            resultA    <= 32'd0;
        end else if (a_load) begin
            regwrite_A <= a_regwrite;
            writeRegA  <= writeRegM;
            resultA    <= a_result;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (memsize_M)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = aluout_M[0];
            default: misaligned = (aluout_M[1:0] != 2'b00);
        endcase
    end

    // a simultaneous read+write request is handled purely as a load
    assign is_load   = memread_M;
    assign is_store  = memwrite_M && !memread_M;
    assign addrerr_M = (memread_M || memwrite_M) && misaligned;

    assign data_sram_addr = aluout_M;

    always_comb begin
        store_wen       = 4'b0000;
        data_sram_wdata = writedata_M;
        case (memsize_M)
            2'b00: begin
                store_wen       = 4'b0001 << aluout_M[1:0];
                data_sram_wdata = {4{writedata_M[7:0]}};
            end
            2'b01: begin
                store_wen       = aluout_M[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{writedata_M[15:0]}};
            end
            default: begin
                store_wen       = 4'b1111;
                data_sram_wdata = writedata_M;
            end
        endcase
    end

    always_comb begin
        load_byte = data_sram_rdata[7:0];
        case (aluout_M[1:0])
            2'b00: load_byte = data_sram_rdata[7:0];
            2'b01: load_byte = data_sram_rdata[15:8];
            2'b10: load_byte = data_sram_rdata[23:16];
            2'b11: load_byte = data_sram_rdata[31:24];
        endcase
        load_half = aluout_M[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (memsize_M)
            2'b00:   load_data = {{24{memsigned_M & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{memsigned_M & load_half[15]}}, load_half};
            default: load_data = data_sram_rdata;
        endcase
    end

    always_comb begin
        state_next    = state;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        stall_M       = 1'b0;
        a_load        = 1'b1;
        a_regwrite    = regwrite_M;
        a_result      = aluout_M;
        case (state)
            IDLE: begin
                if (addrerr_M) begin
                    a_regwrite = 1'b0;
                end else if (is_load) begin
                    data_sram_en = 1'b1;
                    stall_M      = 1'b1;
                    a_load       = 1'b0;
                    state_next   = LOADWAIT;
                end else if (is_store) begin
                    data_sram_en  = 1'b1;
                    data_sram_wen = store_wen;
                end
            end
            LOADWAIT: begin
                a_result   = load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memaccess.sv
// tb/tb_memaccess.sv - directed self-checking bench for memaccess
module tb_memaccess;

    logic        clock;
    logic        reset;
    logic        regwrite_E;
    logic [4:0]  writeRegE;
    logic        memread_E;
    logic        memwrite_E;
    logic [1:0]  memsize_E;
    logic        memsigned_E;
    logic [31:0] aluout_E;
    logic [31:0] writedata_E;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stall_M;
    logic        addrerr_M;
    logic        regwrite_A;
    logic [4:0]  writeRegA;
    logic [31:0] resultA;

    int vectors;
    int miscompares;

    memaccess dut (
        .clock           (clock),
        .reset           (reset),
        .regwrite_E      (regwrite_E),
        .writeRegE       (writeRegE),
        .memread_E       (memread_E),
        .memwrite_E      (memwrite_E),
        .memsize_E       (memsize_E),
        .memsigned_E     (memsigned_E),
        .aluout_E        (aluout_E),
        .writedata_E     (writedata_E),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stall_M         (stall_M),
        .addrerr_M       (addrerr_M),
        .regwrite_A      (regwrite_A),
        .writeRegA       (writeRegA),
        .resultA         (resultA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic rd, input logic wt,
                         input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                         input logic [31:0] wd);
        regwrite_E  = rw;
        writeRegE   = wr;
        memread_E   = rd;
        memwrite_E  = wt;
        memsize_E   = sz;
        memsigned_E = sg;
        aluout_E    = addr;
        writedata_E = wd;
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        data_sram_rdata = 32'd0;
        bubble();

        #2;
        check("rst_regwrite_A", 32'(regwrite_A), 32'd0);
        check("rst_writeRegA", 32'(writeRegA), 32'd0);
        check("rst_resultA", resultA, 32'd0);
        check("rst_en", 32'(data_sram_en), 32'd0);
        check("rst_stall", 32'(stall_M), 32'd0);
        #10;
        reset = 1'b1;
        tick();
        check("rel_en", 32'(data_sram_en), 32'd0);
        check("rel_stall", 32'(stall_M), 32'd0);

        // ALU op, then word load followed by a second ALU op
        drive(1'b1, 5'd1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0055, 32'd0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'd0);
        tick();
        check("alu_resultA", resultA, 32'h0000_0055);
        check("alu_writeRegA", 32'(writeRegA), 32'd1);
        check("wld_stall", 32'(stall_M), 32'd1);
        check("wld_en", 32'(data_sram_en), 32'd1);
        check("wld_wen", 32'(data_sram_wen), 32'd0);
        check("wld_addr", data_sram_addr, 32'h0000_0100);
        drive(1'b1, 5'd7, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'd0);
        tick();
        data_sram_rdata = 32'h8899_AABB;
        check("wait_stall", 32'(stall_M), 32'd0);
        check("wait_en", 32'(data_sram_en), 32'd0);
        check("wait_hold_resultA", resultA, 32'h0000_0055);
        tick();
        check("wld_resultA", resultA, 32'h8899_AABB);
        check("wld_regwrite_A", 32'(regwrite_A), 32'd1);
        check("wld_writeRegA", 32'(writeRegA), 32'd5);
        check("alu2_in_M_en", 32'(data_sram_en), 32'd0);
        bubble();
        tick();
        check("alu2_resultA", resultA, 32'h0000_1234);
        check("alu2_writeRegA", 32'(writeRegA), 32'd7);

        // signed byte load from lane 3
        drive(1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0);
        tick();
        bubble();
        check("bld_stall", 32'(stall_M), 32'd1);
        tick();
        data_sram_rdata = 32'h8011_2233;
        tick();
        check("bld_s_resultA", resultA, 32'hFFFF_FF80);

        // unsigned byte load, same address and data
        drive(1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0);
        tick();
        bubble();
        tick();
        tick();
        check("bld_u_resultA", resultA, 32'h0000_0080);

        // signed half load from upper half
        drive(1'b1, 5'd4, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0);
        tick();
        bubble();
        tick();
        tick();
        check("hld_s_resultA", resultA, 32'hFFFF_8011);

        // back-to-back stores: half at 0x102, byte at 0x101
        drive(1'b0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5678);
        check("hst_wen", 32'(data_sram_wen), 32'hC);
        check("hst_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        check("hst_en", 32'(data_sram_en), 32'd1);
        check("hst_stall", 32'(stall_M), 32'd0);
        check("hst_addrerr", 32'(addrerr_M), 32'd0);
        tick();
        check("bst_wen", 32'(data_sram_wen), 32'h2);
        check("bst_wdata", data_sram_wdata, 32'h7878_7878);
        check("bst_en", 32'(data_sram_en), 32'd1);

        // ALU op then misaligned word load
        drive(1'b1, 5'd2, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_CAFE, 32'd0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'd0);
        tick();
        check("mis_addrerr", 32'(addrerr_M), 32'd1);
        check("mis_en", 32'(data_sram_en), 32'd0);
        check("mis_wen", 32'(data_sram_wen), 32'd0);
        check("mis_stall", 32'(stall_M), 32'd0);
        check("mis_prev_regwrite_A", 32'(regwrite_A), 32'd1);
        bubble();
        tick();
        check("mis_regwrite_A", 32'(regwrite_A), 32'd0);

        // read and write together acts as a load
        drive(1'b1, 5'd6, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
        tick();
        bubble();
        check("rw_en", 32'(data_sram_en), 32'd1);
        check("rw_wen", 32'(data_sram_wen), 32'd0);
        check("rw_stall", 32'(stall_M), 32'd1);
        tick();
        data_sram_rdata = 32'h0BAD_F00D;
        tick();
        check("rw_resultA", resultA, 32'h0BAD_F00D);
        check("rw_writeRegA", 32'(writeRegA), 32'd6);

        // reset asserted while in LOADWAIT
        drive(1'b1, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        tick();
        bubble();
        tick();
        data_sram_rdata = 32'h1111_2222;
        reset = 1'b0;
        #1;
        check("lwrst_regwrite_A", 32'(regwrite_A), 32'd0);
        check("lwrst_writeRegA", 32'(writeRegA), 32'd0);
        check("lwrst_resultA", resultA, 32'd0);
        check("lwrst_en", 32'(data_sram_en), 32'd0);
        check("lwrst_stall", 32'(stall_M), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_en", 32'(data_sram_en), 32'd0);
        check("post_wen", 32'(data_sram_wen), 32'd0);
        check("post_stall", 32'(stall_M), 32'd0);
        check("post_regwrite_A", 32'(regwrite_A), 32'd0);
        check("post_resultA", resultA, 32'd0);
        check("post_addr", data_sram_addr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memaccess.md
MEMACCESS -- requirements
Module: memaccess

Interface
REQ-001 The block SHALL have one clock, `clock`; reset is asynchronous and active-low, on port `reset`.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 regwrite_E  in  1  execute-stage register-write enable.
REQ-005 writeRegE  in  5  execute-stage destination register.
REQ-006 memread_E  in  1  load request.
REQ-007 memwrite_E  in  1  store request.
REQ-008 memsize_E  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 memsigned_E  in  1  1 means the load is sign-extended, 0 means zero-extended.
REQ-010 aluout_E  in  32  ALU result, which is also the memory address.
REQ-011 writedata_E  in  32  store data.
REQ-012 data_sram_en  out  1  SRAM access enable.
REQ-013 data_sram_wen  out  4  byte write strobes.
REQ-014 data_sram_addr  out  32  SRAM byte address.
REQ-015 data_sram_wdata  out  32  SRAM write data.
REQ-016 data_sram_rdata  in  32  SRAM read data, valid the cycle after the request.
REQ-017 stall_M  out  1  combinational stall to the execute stage and upstream.
REQ-018 addrerr_M  out  1  combinational misaligned-access flag.
REQ-019 regwrite_A  out  1  registered write enable to the writeback stage.
REQ-020 writeRegA  out  5  registered destination register to writeback.
REQ-021 resultA  out  32  registered result to writeback.

Function
REQ-022 The M register (all *_E inputs) SHALL capture on each posedge where stall_M=0 and hold its value where stall_M=1.
REQ-023 The FSM SHALL have two states, IDLE and LOADWAIT.
REQ-024 IDLE with an aligned load in M SHALL drive: data_sram_en=1, wen=0000, stall_M=1, next state LOADWAIT; the A registers take no new instruction.
REQ-025 LOADWAIT SHALL drive: data_sram_en=0, stall_M=0; on the posedge, A latches the extracted rdata with regwrite_M and writeRegM; next state IDLE.
REQ-026 Load latency: the load result SHALL appear in A two cycles after the load enters M; all non-load instructions take one cycle.
REQ-027 Load extraction: the byte lane SHALL be selected by addr[1:0] and the half lane by addr[1]; extend to 32 bits per memsigned_M; a word load passes rdata unchanged.
REQ-028 An aligned store in IDLE SHALL drive data_sram_en=1 for one cycle with no stall.
REQ-029 Store strobes: byte SHALL use wen=0001<<addr[1:0]; half SHALL use 0011 (addr[1]=0) or 1100 (addr[1]=1); word SHALL use 1111.
REQ-030 Store data: byte SHALL replicate the low byte four times; half SHALL replicate the low half twice; word SHALL pass the data unchanged.
REQ-031 data_sram_addr SHALL equal aluout_M at all times.
REQ-032 Misaligned access (half with addr[0]=1, or word with addr[1:0]≠00) SHALL drive: addrerr_M=1, data_sram_en=0, wen=0000, no stall; A latches regwrite_A=0.
REQ-033 When memread_M and memwrite_M are both 1, the access SHALL be treated as a load and memwrite ignored.
REQ-034 A non-memory instruction SHALL drive: resultA<=aluout_M, regwrite_A<=regwrite_M, writeRegA<=writeRegM in one cycle.
REQ-035 Outside the conditions of REQ-024 and REQ-028, data_sram_en SHALL be 0 and data_sram_wen SHALL be 0000.

Reset
REQ-036 With reset=0, the block SHALL asynchronously force: FSM=IDLE; all M fields=0 (a bubble); regwrite_A=0, writeRegA=00000, resultA=0.
REQ-037 Reset asserted during LOADWAIT SHALL drop the load with no write reaching A.
REQ-038 The first cycle after reset release SHALL drive data_sram_en=0 and stall_M=0.

Verification
REQ-039 Word load: addr 0x100, rdata=0x8899AABB, signed -> stall_M=1 for one cycle, then resultA=0x8899AABB with regwrite_A=1.
REQ-040 Byte load: addr 0x103, rdata=0x80112233, signed -> resultA=0xFFFFFF80; the same case unsigned -> resultA=0x00000080.
REQ-041 Half store: addr 0x102, data 0x0000BEEF -> wen=1100, wdata=0xBEEFBEEF, en=1, no stall.
REQ-042 Word load at addr 0x101 -> addrerr_M=1, en=0, no stall, regwrite_A=0 the next cycle.
REQ-043 Load followed by an ALU instruction -> the ALU instruction is held in execute during IDLE, enters M at the end of LOADWAIT, and reaches A one cycle after the load.
REQ-044 Reset asserted in LOADWAIT, then released -> all outputs 0, FSM=IDLE, no SRAM access.
